seq_mult: RTL and testbench
===========================

Name: seq_mult

Overview:
Parametrised sequential shift-and-add multiplier for the ALU datapath. It generalises the opcode-driven multiply flow run on the control block: load, AND-with-LSB, shift, accumulate, then 2's-complement fix-up. Here that flow is self-sequenced by an internal FSM behind a start/done handshake. It supports any operand width and a runtime signed/unsigned mode.

Parameters:
WIDTH, 16, operand width in bits (>=2); product is 2*WIDTH bits.
SIGNED_EN, 1, when 0 the signed input is ignored and all operations are unsigned.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous reset, active-low.
start  input  1  request pulse or level; sampled only in IDLE.
signed_op  input  1  1 = two's-complement operands; sampled with start.
a  input  WIDTH  multiplicand; sampled with start.
b  input  WIDTH  multiplier; sampled with start.
busy  output  1  high while an operation is in flight (RUN or FIX).
done  output  1  one-cycle pulse when product is updated.
product  output  2*WIDTH  result register; holds until the next completion.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, product=0, and all internal registers 0.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - If start=1 at a rising edge (E0), latch mode s = signed_op & SIGNED_EN.
  - Latch mcand = s ? |a| : a, zero-extended to 2*WIDTH.
  - Latch mplier = s ? |b| : b.
  - Latch neg = s & (a[MSB] ^ b[MSB]).
  - Clear acc and count. Go to RUN; busy=1 from E0.
- RUN (exactly WIDTH edges, E1..E_WIDTH):
  - acc += mplier[0] ? mcand : 0.
  - mcand <<= 1; mplier >>= 1; count++.
  - After count reaches WIDTH-1 and that edge completes, go to FIX.
- FIX (edge E_WIDTH+1):
  - product <= neg ? -acc : acc, truncated to 2*WIDTH.
  - done=1 for this one cycle; busy=0; go to IDLE.
- Latency: start edge to done = WIDTH+1 clocks. A new start may be accepted on the edge immediately after done, giving back-to-back throughput of WIDTH+2 clocks.
- Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), representable in WIDTH unsigned bits. No overflow is possible: the full 2*WIDTH product is always exact.
- Zero operand: still takes the full WIDTH cycles (no early exit). neg with a zero acc yields 0, never negative zero.
- start asserted while busy=1 is ignored; operands are not re-sampled.
- a, b and signed_op may change freely after E0.
- Reset mid-operation: immediate abort to the reset values. product is cleared to 0 and no done pulse is issued.
- done and start on the same edge (state IDLE after FIX): a new operation is accepted normally.

Decomposition:
- Shared package alu_pkg: state encoding constants (IDLE=2'd0, RUN=2'd1, FIX=2'd2) and the default WIDTH.
- Counter width is $clog2(WIDTH), local.
- One natural sub-module: twos_neg, a parametrised conditional two's-complement negate. It is reused for the input magnitude (WIDTH) and the output fix-up (2*WIDTH).

Test Plan:
- WIDTH=16, signed_op=1, a=-8 (0xFFF8), b=-15 (0xFFF1), start 1 cycle -> done exactly 17 clocks later, product=0x00000078 (120), busy high for 17 cycles.
- signed_op=1, a=5, b=-14 -> product=0xFFFFFFBA (-70); then signed_op=0, a=5, b=14 -> product=0x00000046.
- signed_op=0, a=0xFFFF, b=0xFFFF -> product=0xFFFE0001; signed_op=1, a=0x8000, b=0x8000 -> product=0x40000000.
- Start held high with a=3, b=4, changing to a=7 after E0 -> first product=12. A second operation auto-starts on the edge after done and samples the current operands; done pulses once every 18 clocks.
- rst_n driven low asynchronously mid-RUN (8 clocks after start) -> busy, done and product go to 0 immediately with no clock edge. After release, a=2, b=3 -> product=6.
- SIGNED_EN=0 build, signed_op=1, a=0xFFFF, b=2 -> product=0x0001FFFE (unsigned result).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding and default operand width.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/twos_neg.sv
// Conditional two's-complement negate; passes din through when neg is low.
module twos_neg #(
  parameter int W = 16
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  always_comb begin
    dout = din;
    if (neg) dout = ~din + W'(1);
  end

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-and-add multiplier: magnitudes are multiplied over WIDTH
// cycles, then the sign is restored in a single fix-up cycle.
//   state | meaning
//   IDLE  | waiting for start; operands and mode latched on start
//   RUN   | one partial product accumulated per cycle, WIDTH cycles
//   FIX   | sign fix-up written to product, done pulsed
module seq_mult
  import alu_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t          state, state_nx;
  logic            s_op;
  logic            neg_a, neg_b;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]   mcand, acc, acc_fix;
  logic [WIDTH-1:0] mplier;
  logic            neg;
  logic [CW-1:0]   count;
  logic            last;

  assign s_op  = signed_op & SIGNED_EN;
  assign neg_a = s_op & a[WIDTH-1];
  assign neg_b = s_op & b[WIDTH-1];
  assign last  = (count == CW'(WIDTH - 1));
  assign busy  = (state != IDLE);

  // -2^(WIDTH-1) negates to itself, which read unsigned is the correct magnitude
  twos_neg #(.W(WIDTH)) u_abs_a (.neg(neg_a), .din(a), .dout(a_mag));
  twos_neg #(.W(WIDTH)) u_abs_b (.neg(neg_b), .din(b), .dout(b_mag));
  twos_neg #(.W(PW))    u_fix   (.neg(neg),   .din(acc), .dout(acc_fix));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      neg     <= 1'b0;
      count   <= '0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            neg    <= neg_a ^ neg_b;
            acc    <= '0;
            count  <= '0;
          end
        end
        RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
        end
        FIX: begin
          product <= acc_fix;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// Directed and random checks of seq_mult (signed and unsigned-only builds)
// against an arithmetic reference model.
module tb_seq_mult;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          signed_op = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy_s, done_s, busy_u, done_u;
  logic [2*W-1:0] product_s, product_u;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  seq_mult #(.WIDTH(W), .SIGNED_EN(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
    .a(a), .b(b), .busy(busy_s), .done(done_s), .product(product_s)
  );

  seq_mult #(.WIDTH(W), .SIGNED_EN(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
    .a(a), .b(b), .busy(busy_u), .done(done_u), .product(product_u)
  );

  function automatic logic [2*W-1:0] ref_mul(bit sop, logic [W-1:0] x, logic [W-1:0] y);
    longint xv, yv;
    if (sop) begin
      xv = longint'($signed(x));
      yv = longint'($signed(y));
    end else begin
      xv = longint'(x);
      yv = longint'(y);
    end
    return (2*W)'(xv * yv);
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Issue one single-cycle start and check latency, busy span, products.
  task automatic run_op(string tag, bit sop, logic [W-1:0] x, logic [W-1:0] y);
    int cyc;
    int busy_cnt;
    @(negedge clk);
    start = 1'b1; signed_op = sop; a = x; b = y;
    @(posedge clk); #1;
    busy_cnt = busy_s ? 1 : 0;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); signed_op = ~sop;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (busy_s) busy_cnt++;
    end while (!done_s && cyc < 40);
    check({tag, "_latency"}, 64'(cyc), 64'(W + 1));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(W + 1));
    check({tag, "_prod_signed_build"}, 64'(product_s), 64'(ref_mul(sop, x, y)));
    check({tag, "_prod_unsigned_build"}, 64'(product_u), 64'(ref_mul(1'b0, x, y)));
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, 64'(done_s), 64'(0));
  endtask

  initial begin
    int cyc;
    #2;
    check("reset_busy", 64'(busy_s), 64'(0));
    check("reset_done", 64'(done_s), 64'(0));
    check("reset_product", 64'(product_s), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    run_op("neg_neg", 1'b1, 16'hFFF8, 16'hFFF1);
    check("neg_neg_const", 64'(product_s), 64'h0000_0078);
    run_op("pos_neg", 1'b1, 16'd5, 16'hFFF2);
    check("pos_neg_const", 64'(product_s), 64'hFFFF_FFBA);
    run_op("unsigned_small", 1'b0, 16'd5, 16'd14);
    check("unsigned_small_const", 64'(product_s), 64'h0000_0046);
    run_op("unsigned_max", 1'b0, 16'hFFFF, 16'hFFFF);
    check("unsigned_max_const", 64'(product_s), 64'hFFFE_0001);
    run_op("min_min", 1'b1, 16'h8000, 16'h8000);
    check("min_min_const", 64'(product_s), 64'h4000_0000);
    run_op("unsigned_build_signed_req", 1'b1, 16'hFFFF, 16'd2);
    check("unsigned_build_const", 64'(product_u), 64'h0001_FFFE);
    run_op("zero_neg", 1'b1, 16'd0, 16'hFFFB);
    run_op("min_pos", 1'b1, 16'h8000, 16'h7FFF);

    for (int i = 0; i < 10; i++)
      run_op($sformatf("rand%0d", i), 1'($urandom), W'($urandom), W'($urandom));

    // Start held high: second op auto-starts after done with current operands
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; a = 16'd3; b = 16'd4;
    @(posedge clk);
    @(negedge clk);
    a = 16'd7;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!done_s && cyc < 40);
    check("held_first_latency", 64'(cyc), 64'(W + 1));
    check("held_first_product", 64'(product_s), 64'd12);
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!done_s && cyc < 40);
    start = 1'b0;
    check("held_period", 64'(cyc), 64'(W + 2));
    check("held_second_product", 64'(product_s), 64'd28);
    repeat (2) @(posedge clk);
    #1;
    check("held_released_idle", 64'(busy_s), 64'(0));

    // Asynchronous reset mid-RUN
    @(negedge clk);
    start = 1'b1; signed_op = 1'b1; a = 16'd1000; b = 16'd77;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    check("pre_reset_busy", 64'(busy_s), 64'(1));
    rst_n = 1'b0;
    #1;
    check("async_reset_busy", 64'(busy_s), 64'(0));
    check("async_reset_done", 64'(done_s), 64'(0));
    check("async_reset_product", 64'(product_s), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold_no_done", 64'(done_s), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset", 1'b0, 16'd2, 16'd3);
    check("after_reset_const", 64'(product_s), 64'd6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
